kt1_code_rx: RTL and testbench

Receive-side counterpart of the KT1 3-to-8 output decoder. It accepts 8-bit D words, recovers the decoder's control fields (A, B, S) from each word and queues the results in a 2-entry FIFO with a valid/ready output. Idle words are dropped, and illegal words are flagged and counted. It sits between the decoder's D bus, or a loopback of it, and any consumer that needs the original selection back.

---
 rtl/kt1_code_rx_pkg.sv | 53 +++++
 rtl/kt1_code_rx_fifo2.sv | 66 ++++++
 rtl/kt1_code_rx.sv | 103 ++++++++++
 tb/tb_kt1_code_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/kt1_code_rx_pkg.sv
// kt1_code_rx_pkg: shared KT1 constants, FIFO entry layout and word
// classification helpers. The KT1 decoder uses the same constants so that
// both ends agree on the D-word encoding.
//   KT1_PAT_AB : D word produced when B selects the AB pattern
//   KT1_IDLE   : D word produced for E=0 or A=B (no selection)
//   Entry layout {A[4], B[3], S[2:0]}
package kt1_code_rx_pkg;

    localparam int D_W     = 8;
    localparam int S_W     = 3;
    localparam int ENTRY_W = 5;

    localparam logic [D_W-1:0] KT1_PAT_AB = 8'hCC;
    localparam logic [D_W-1:0] KT1_IDLE   = 8'h00;

    localparam int ENT_A    = 4;
    localparam int ENT_B    = 3;
    localparam int ENT_S_HI = 2;
    localparam int ENT_S_LO = 0;

    typedef enum logic [1:0] {
        CLS_IDLE    = 2'd0,
        CLS_ONEHOT  = 2'd1,
        CLS_AB      = 2'd2,
        CLS_ILLEGAL = 2'd3
    } word_class_e;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [D_W-1:0] d);
        return (d != 8'h00) && ((d & (d - 8'd1)) == 8'h00);
    endfunction

    // Index of the highest set bit; only meaningful for one-hot words.
    function automatic logic [S_W-1:0] onehot_index(input logic [D_W-1:0] d);
        logic [S_W-1:0] idx;
        idx = 3'd0;
        for (int i = 0; i < D_W; i++) begin
            if (d[i]) begin
                idx = S_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic a,
                                                      input logic b,
                                                      input logic [S_W-1:0] s);
        return {a, b, s};
    endfunction

endpackage

// File: rtl/kt1_code_rx_fifo2.sv
// kt1_fifo2: 2-entry synchronous FIFO with 1-bit pointers.
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write request and data (ignored when full)
//   pop           : read request (ignored when empty)
//   dout          : head entry, forced to 0 when empty
//   full, empty   : occupancy flags
module kt1_fifo2
    import kt1_code_rx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy; a push and pop together keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= 5'd0;
            mem_r[1] <= 5'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head read port; empty FIFO presents zeros rather than stale data.
    always_comb begin
        dout = 5'd0;
        if (empty) begin
            dout = 5'd0;
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/kt1_code_rx.sv
// kt1_code_rx: receive side of the KT1 3-to-8 decoder. Classifies D words,
// queues recovered {A,B,S} in a 2-entry FIFO, drops idle words and flags
// and counts illegal ones.
//   clk, rst            : clock, synchronous active-high reset
//   en                  : accept enable (FIFO keeps draining when low)
//   d_in, d_valid       : incoming D word; d_ready = en && !full (0 in reset)
//   out_valid/out_ready : FIFO head handshake; a_out, b_out, s_out = head
//   err                 : registered one-cycle pulse per accepted illegal word
//   clr_err             : clears err_count, wins over a same-cycle increment
//   err_count           : saturating illegal-word count
module kt1_code_rx
    import kt1_code_rx_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_out,
    output logic             b_out,
    output logic [2:0]       s_out,
    output logic             err,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    word_class_e        cls_s;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_s;
    logic               accept_s;
    logic               push_s;
    logic               illegal_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               err_r;
    logic [ERR_W-1:0]   err_count_r;

    assign d_ready   = en && !fifo_full_s && !rst;
    assign accept_s  = d_valid && d_ready;
    assign push_s    = accept_s && ((cls_s == CLS_ONEHOT) || (cls_s == CLS_AB));
    assign illegal_s = accept_s && (cls_s == CLS_ILLEGAL);

    // Word classifier and the entry it would push.
    always_comb begin
        cls_s   = CLS_ILLEGAL;
        entry_s = 5'd0;
        if (d_in == KT1_IDLE) begin
            cls_s = CLS_IDLE;
        end else if (d_in == KT1_PAT_AB) begin
            cls_s   = CLS_AB;
            entry_s = pack_entry(1'b0, 1'b1, 3'd0);
        end else if (is_onehot(d_in)) begin
            cls_s   = CLS_ONEHOT;
            entry_s = pack_entry(1'b1, 1'b0, onehot_index(d_in));
        end else begin
            cls_s = CLS_ILLEGAL;
        end
    end

    kt1_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (entry_s),
        .pop   (out_ready),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign out_valid = !fifo_empty_s;
    assign a_out     = head_s[ENT_A];
    assign b_out     = head_s[ENT_B];
    assign s_out     = head_s[ENT_S_HI:ENT_S_LO];

    // Error pulse and saturating counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r       <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
        end else begin
            err_r <= illegal_s;
            if (clr_err) begin
                err_count_r <= {ERR_W{1'b0}};
            end else if (illegal_s && (err_count_r != ERR_MAX)) begin
                err_count_r <= err_count_r + ERR_W'(1);
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign err       = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_kt1_code_rx.sv
// tb_kt1_code_rx: directed stimulus with a scoreboard queue of expected
// {A,B,S} entries and an independent output monitor.
module tb_kt1_code_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] d_in;
    logic       d_valid;
    logic       d_ready;
    logic       out_valid;
    logic       out_ready;
    logic       a_out;
    logic       b_out;
    logic [2:0] s_out;
    logic       err;
    logic       clr_err;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    logic [4:0] sb [$];

    always #5 clk = ~clk;

    kt1_code_rx #(.ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .s_out     (s_out),
        .err       (err),
        .clr_err   (clr_err),
        .err_count (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rise.
    always @(negedge clk) begin
        if (err) err_seen++;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {27'd0, a_out, b_out, s_out}, 32'hFFFF_FFFF);
            end else begin
                chk("head_abs", {27'd0, a_out, b_out, s_out}, {27'd0, sb.pop_front()});
            end
        end
    end

    // Present one word and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] w, input bit has_exp, input logic [4:0] e);
        bit ok;
        ok = 1'b0;
        d_in    = w;
        d_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        if (has_exp) sb.push_back(e);
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; d_in = 8'h01; d_valid = 1'b1;
        out_ready = 1'b0; clr_err = 1'b0;

        // Reset with a pending word: nothing accepted, d_ready low.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_err_count", {24'd0, err_count}, 32'd0);
            chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; d_valid = 1'b0;
        chk("post_rst_err", {31'd0, err}, 32'd0);
        chk("post_rst_abs", {27'd0, a_out, b_out, s_out}, 32'd0);

        // One-hot sweep, back-to-back, consumer always ready.
        out_ready = 1'b1;
        send(8'h01, 1'b1, 5'b10_000);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        send(8'h02, 1'b1, 5'b10_001);
        send(8'h04, 1'b1, 5'b10_010);
        send(8'h08, 1'b1, 5'b10_011);
        send(8'h10, 1'b1, 5'b10_100);
        send(8'h20, 1'b1, 5'b10_101);
        send(8'h40, 1'b1, 5'b10_110);
        send(8'h80, 1'b1, 5'b10_111);
        cycles(1);
        chk("sweep_drained", sb.size(), 32'd0);
        chk("sweep_empty", {31'd0, out_valid}, 32'd0);

        // AB pattern and idle word.
        err_seen = 0;
        send(8'hCC, 1'b1, 5'b01_000);
        send(8'h00, 1'b0, 5'd0);
        send(8'h10, 1'b1, 5'b10_100);
        cycles(2);
        chk("pat_drained", sb.size(), 32'd0);
        chk("pat_no_err", err_seen, 32'd0);

        // Illegal words: no pushes, err pulses, counter saturates.
        send(8'h03, 1'b0, 5'd0);
        chk("ill_err_pulse", {31'd0, err}, 32'd1);
        chk("ill_no_push", {31'd0, out_valid}, 32'd0);
        chk("ill_count1", {24'd0, err_count}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            send(8'hFF, 1'b0, 5'd0);
            if (i % 50 == 0) chk("ill_err_ff", {31'd0, err}, 32'd1);
        end
        chk("sat_count", {24'd0, err_count}, 32'd255);
        chk("sat_no_push", {31'd0, out_valid}, 32'd0);
        cycles(1);
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        clr_err = 1'b1;
        send(8'hFF, 1'b0, 5'd0);
        clr_err = 1'b0;
        chk("clr_wins", {24'd0, err_count}, 32'd0);

        // Backpressure: two fill the FIFO, third waits.
        out_ready = 1'b0;
        send(8'h04, 1'b1, 5'b10_010);
        send(8'h08, 1'b1, 5'b10_011);
        d_in = 8'h20; d_valid = 1'b1;
        cycles(3);
        chk("bp_d_ready", {31'd0, d_ready}, 32'd0);
        chk("bp_head_hold", {27'd0, a_out, b_out, s_out}, 32'b10_010);
        chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        send(8'h20, 1'b1, 5'b10_101);
        cycles(3);
        chk("bp_drained", sb.size(), 32'd0);

        // Enable low blocks acceptance while the FIFO drains.
        out_ready = 1'b0;
        send(8'h01, 1'b1, 5'b10_000);
        send(8'h02, 1'b1, 5'b10_001);
        en = 1'b0; d_in = 8'h40; d_valid = 1'b1;
        #1;
        chk("en_low_ready", {31'd0, d_ready}, 32'd0);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        chk("en_drain_one", sb.size(), 32'd1);
        chk("en_low_ready2", {31'd0, d_ready}, 32'd0);
        chk("en_head", {27'd0, a_out, b_out, s_out}, 32'b10_001);
        en = 1'b1;
        send(8'h40, 1'b1, 5'b10_110);
        chk("full_again", {31'd0, d_ready}, 32'd0);

        // Mid-stream reset with two entries queued.
        rst = 1'b1; d_in = 8'h01; d_valid = 1'b1;
        cycles(1);
        sb.delete();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_abs", {27'd0, a_out, b_out, s_out}, 32'd0);
        rst = 1'b0; d_valid = 1'b0;
        cycles(1);
        chk("after_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
